// File: rtl/fp32_result_drain_if.sv
// Bundle between the MAC row, fp32_result_drain and the downstream consumer.
// The row-capture side, the serialized word stream and the status signals
// all travel together. The master modport is the drain's view: it sources
// the word stream and the status signals. The slave modport is the
// environment's view: it sources rows, ready and the overflow clear.
interface fp32_result_drain_if #(
    parameter int NUM_COLS = 4,
    parameter int DEPTH    = 8
);
    localparam int CW = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam int NW = $clog2(DEPTH) + 1;

    logic                    row_valid;
    logic [NUM_COLS*32-1:0]  row_y;
    logic                    out_valid;
    logic                    out_ready;
    logic [31:0]             out_data;
    logic [CW-1:0]           out_col;
    logic                    out_last;
    logic [NW-1:0]           count;
    logic                    overflow;
    logic                    clr_ovf;

    modport master (
        input  row_valid, row_y, out_ready, clr_ovf,
        output out_valid, out_data, out_col, out_last, count, overflow
    );

    modport slave (
        output row_valid, row_y, out_ready, clr_ovf,
        input  out_valid, out_data, out_col, out_last, count, overflow
    );
endinterface

// File: rtl/fp32_result_drain.sv
// fp32_result_drain: captures whole rows of FP32 MAC results into a row FIFO
// and serializes them, column 0 first, onto one 32-bit valid/ready stream.
// The MAC row cannot be stalled, so a row arriving with the FIFO full (and no
// pop on that cycle) is dropped and a sticky overflow flag is raised.
// Optional build macro FP32_DRAIN_RELU_EN: applies ReLU at the output mux
// (negative non-NaN words become +0.0); FIFO contents are never altered.
module fp32_result_drain #(
    parameter int NUM_COLS = 4,
    parameter int DEPTH    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    fp32_result_drain_if.master   bus
);
    localparam int CW = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam int PW = $clog2(DEPTH);
    localparam int NW = PW + 1;
    localparam logic [CW-1:0] LAST_COL = CW'(NUM_COLS - 1);
    localparam logic [NW-1:0] FULL_CNT = NW'(DEPTH);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                 state_reg, state_next;
    logic [CW-1:0]          col_reg, col_next;
    logic [PW-1:0]          wr_ptr_reg, rd_ptr_reg;
    logic [NW-1:0]          count_reg, count_next;
    logic                   ovf_reg, ovf_next;

    // Row storage; no reset so it maps onto RAM.
    logic [NUM_COLS*32-1:0] mem [DEPTH];
    logic [NUM_COLS*32-1:0] head_row;
    logic [31:0]            head_words [NUM_COLS];
    logic [31:0]            word_sel;
    logic [31:0]            word_out;

    logic sending, is_last, handshake, pop, push, drop;

    assign sending   = (state_reg == SEND);
    assign is_last   = (col_reg == LAST_COL);
    assign handshake = sending && bus.out_ready;
    assign pop       = handshake && is_last;
    // A pop on the same cycle frees the slot, so a full FIFO still accepts.
    assign push      = bus.row_valid && ((count_reg != FULL_CNT) || pop);
    assign drop      = bus.row_valid && !push;

    // Row occupancy bookkeeping; the row being emitted still counts.
    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    // Next-state logic: word sequencing within a row and IDLE/SEND control.
    always_comb begin
        state_next = state_reg;
        col_next   = col_reg;
        ovf_next   = ovf_reg;
        case (state_reg)
            IDLE: begin
                // Looking at the post-push occupancy gives first word one
                // cycle after the row is captured.
                if (count_next != '0)
                    state_next = SEND;
            end
            SEND: begin
                if (handshake) begin
                    if (is_last) begin
                        col_next = '0;
                        if (count_next == '0)
                            state_next = IDLE;
                    end else begin
                        col_next = col_reg + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        // A drop on the same cycle as a clear leaves the flag set.
        if (drop)
            ovf_next = 1'b1;
        else if (bus.clr_ovf)
            ovf_next = 1'b0;
    end

    // Control registers with asynchronous reset; a reset discards everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            col_reg    <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            ovf_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            col_reg   <= col_next;
            count_reg <= count_next;
            ovf_reg   <= ovf_next;
            if (push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    // Row write into storage at the write pointer.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_reg] <= bus.row_y;
    end

    assign head_row = mem[rd_ptr_reg];

    generate
        for (genvar gi = 0; gi < NUM_COLS; gi++) begin : g_split
            assign head_words[gi] = head_row[32*gi +: 32];
        end
    endgenerate

    assign word_sel = head_words[col_reg];

`ifdef FP32_DRAIN_RELU_EN
    // ReLU on the outgoing word: negatives (incl. -0.0, -Inf) to +0.0, NaN kept.
    always_comb begin
        word_out = word_sel;
        if (word_sel[31] && !((word_sel[30:23] == 8'hFF) && (word_sel[22:0] != '0)))
            word_out = '0;
    end
`else
    assign word_out = word_sel;
`endif

    assign bus.out_valid = sending;
    assign bus.out_data  = sending ? word_out : '0;
    assign bus.out_col   = sending ? col_reg : '0;
    assign bus.out_last  = sending && is_last;
    assign bus.count     = count_reg;
    assign bus.overflow  = ovf_reg;
endmodule
